fetch_stage: RTL and testbench

//  Two-stage instruction fetch front end (IF1/IF2) in the cpu_clk domain. Generates the
//  pc_if1/pc_if2 addresses consumed by the instruction cache and captures its instr/stall

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_skid_fifo.sv | 50 +++++
 rtl/fetch_stage.sv | 81 ++++++++
 tb/tb_fetch_stage.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch front end.
package fetch_pkg;

  localparam logic [31:0] PC_INVALID = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid FIFO holding fetched {pc, instr} pairs for decode.
// A flush empties the FIFO and takes precedence over a same-cycle push or pop.
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic         cpu_clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         empty,
  output logic         full,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   cnt;

  // Pointer and occupancy tracking; a push while full is only ever paired with a pop.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Entry storage; contents are don't-care while the slot is not occupied.
  always_ff @(posedge cpu_clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (cnt == 2'd0);
  assign full  = (cnt == 2'd2);
  assign count = cnt;

endmodule

// File: rtl/fetch_stage.sv
// Two-stage instruction fetch (IF1/IF2) with a skid FIFO towards decode.
// pc_if1 is the address presented to the cache; pc_if2 is the address whose
// instruction is being returned, or PC_INVALID when IF2 holds a bubble.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        cpu_clk,
  input  logic        reset_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        icache_stall,
  input  logic [31:0] icache_instr,
  input  logic        decode_ready,
  output logic [31:0] pc_if1,
  output logic [31:0] pc_if2,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  fetch_entry_t fifo_din;
  fetch_entry_t fifo_dout;
  logic         fifo_empty;
  logic         fifo_full;
  logic [1:0]   fifo_count;
  logic         pop;
  logic         can_push;
  logic         advance;
  logic         push;
  logic [2:0]   fifo_unused;

  assign fifo_unused = {fifo_full, redirect_pc[1:0]};

  assign if_valid = !fifo_empty;
  assign pop      = if_valid && decode_ready;
  assign can_push = (fifo_count < 2'd2) || pop;
  assign advance  = !redirect_valid && !icache_stall && can_push;
  assign push     = advance && (pc_if2 != PC_INVALID);
  assign fifo_din = '{pc: pc_if2, instr: icache_instr};

  // PC pipeline: redirect wins over everything, otherwise step only when the
  // cache has answered and the FIFO can take the IF2 result.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_if1 <= RESET_PC;
      pc_if2 <= PC_INVALID;
    end else if (redirect_valid) begin
      pc_if1 <= {redirect_pc[31:2], 2'b00};
      pc_if2 <= PC_INVALID;
    end else if (advance) begin
      pc_if2 <= pc_if1;
      pc_if1 <= pc_if1 + 32'd4;
    end
  end

  fetch_skid_fifo u_fifo (
    .cpu_clk (cpu_clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  // Decode sees a NOP and PC 0 whenever nothing valid is buffered.
  always_comb begin
    if_instr = NOP_INSTR;
    if_pc    = 32'h0000_0000;
    if (if_valid) begin
      if_instr = fifo_dout.instr;
      if_pc    = fifo_dout.pc;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cache model returns a PC-derived word for pc_if2,
// a scoreboard holds the expected delivered PC stream.
module tb_fetch_stage;

  logic        cpu_clk = 1'b0;
  logic        reset_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        icache_stall;
  logic [31:0] icache_instr;
  logic        decode_ready;
  logic [31:0] pc_if1;
  logic [31:0] pc_if2;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int n_checks = 0;
  int n_errors = 0;
  int n_deliv  = 0;
  int d0;
  logic [31:0] exp_q [$];

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .cpu_clk        (cpu_clk),
    .reset_n        (reset_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .icache_stall   (icache_stall),
    .icache_instr   (icache_instr),
    .decode_ready   (decode_ready),
    .pc_if1         (pc_if1),
    .pc_if2         (pc_if2),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  always #5 cpu_clk = ~cpu_clk;

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return (pc ^ 32'h5A5A_0000) + 32'h0000_0013;
  endfunction

  // Cache model: data for pc_if2 is present while not stalled, junk otherwise.
  assign icache_instr = icache_stall ? 32'hDEAD_BEEF : mem_word(pc_if2);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rebuild(input logic [31:0] start);
    logic [31:0] p;
    exp_q.delete();
    p = start;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(p);
      p = p + 32'd4;
    end
  endtask

  // One clock: check any handshake at the falling edge, then step past the rising edge.
  task automatic step();
    logic [31:0] e;
    @(negedge cpu_clk);
    if (if_valid && decode_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("if_pc", if_pc, e);
        chk("if_instr", if_instr, mem_word(e));
        n_deliv++;
      end
    end
    if (redirect_valid) rebuild({redirect_pc[31:2], 2'b00});
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic after_release_checks();
    step();
    chk("e1_pc_if1", pc_if1, 32'h4);
    chk("e1_pc_if2", pc_if2, 32'h0);
    chk("e1_valid", {31'd0, if_valid}, 32'd0);
    step();
    chk("e2_valid", {31'd0, if_valid}, 32'd1);
    chk("e2_if_pc", if_pc, 32'h0);
    chk("e2_pc_if1", pc_if1, 32'h8);
  endtask

  initial begin
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    icache_stall   = 1'b0;
    decode_ready   = 1'b1;
    repeat (2) @(posedge cpu_clk);
    #1;
    chk("rst_pc_if1", pc_if1, 32'h0);
    chk("rst_pc_if2", pc_if2, 32'hFFFF_FFFF);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'h0000_0013);
    chk("rst_if_pc", if_pc, 32'h0);
    rebuild(32'h0);
    #1 reset_n = 1'b1;

    // Streaming with hits
    after_release_checks();
    repeat (4) step();
    chk("s1_pc_if1", pc_if1, 32'd24);

    // Cache stall: PCs frozen, FIFO drains
    icache_stall = 1'b1;
    repeat (5) step();
    chk("s2_pc_if1", pc_if1, 32'd24);
    chk("s2_pc_if2", pc_if2, 32'd20);
    chk("s2_valid", {31'd0, if_valid}, 32'd0);
    icache_stall = 1'b0;
    repeat (5) step();
    chk("s2_resume_pc_if1", pc_if1, 32'd44);

    // Decode backpressure: FIFO fills, IF holds
    decode_ready = 1'b0;
    repeat (4) step();
    chk("s3_pc_if1", pc_if1, 32'd48);
    chk("s3_pc_if2", pc_if2, 32'd44);
    chk("s3_valid", {31'd0, if_valid}, 32'd1);
    chk("s3_if_pc", if_pc, 32'd36);
    decode_ready = 1'b1;
    repeat (3) step();
    chk("s3_full_pc_if1", pc_if1, 32'd60);

    // Redirect during stall with a full FIFO
    icache_stall   = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0102;
    step();
    redirect_valid = 1'b0;
    chk("s4_pc_if1", pc_if1, 32'h0040_0100);
    chk("s4_pc_if2", pc_if2, 32'hFFFF_FFFF);
    chk("s4_valid", {31'd0, if_valid}, 32'd0);
    icache_stall = 1'b0;
    d0 = n_deliv;
    repeat (6) step();
    chk("s4_deliv", n_deliv - d0, 32'd4);

    // Redirect near the top of the address space, wrap to zero
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    chk("s5_pc_if1_a", pc_if1, 32'hFFFF_FFF8);
    d0 = n_deliv;
    step();
    chk("s5_pc_if1_b", pc_if1, 32'hFFFF_FFFC);
    step();
    chk("s5_pc_if1_c", pc_if1, 32'h0000_0000);
    repeat (6) step();
    chk("s5_deliv", n_deliv - d0, 32'd6);

    // Asynchronous reset with a full FIFO
    decode_ready = 1'b0;
    repeat (3) step();
    chk("s6_pre_valid", {31'd0, if_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("s6_valid", {31'd0, if_valid}, 32'd0);
    chk("s6_instr", if_instr, 32'h0000_0013);
    chk("s6_pc_if1", pc_if1, 32'h0);
    chk("s6_pc_if2", pc_if2, 32'hFFFF_FFFF);
    rebuild(32'h0);
    decode_ready = 1'b1;
    @(posedge cpu_clk);
    #2 reset_n = 1'b1;
    after_release_checks();
    d0 = n_deliv;
    repeat (6) step();
    chk("s6_deliv", n_deliv - d0, 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
